// File: rtl/quadport_ram_arbiter.sv
// -----------------------------------------------------------------------------
// quadport_ram_arbiter
//   Arbitrates four cores onto a shared 4-port RAM. Each cycle, every core
//   whose access does not hazard against a higher-priority granted access is
//   granted. A hazard is two in-range accesses to the same address where at
//   least one is a write. Priority rotates, and a denied core becomes the
//   top-priority core on the next cycle.
//
// Ports (n = 1..4):
//   clk, rst_n         clock, asynchronous active-low reset
//   req_n/we_n/addr_n/wdata_n   core request, direction, address, write data
//   gnt_n              combinational grant (forced 0 while in reset)
//   rvalid_n/rdata_n   registered read-valid strobe, passthrough read data
//   err_n              registered one-cycle out-of-range pulse
//   ram_we_n/ram_re_n/ram_addr_n/ram_din_n/ram_dout_n   RAM port n
//   conflict_cnt       saturating count of cycles with any denied request
// -----------------------------------------------------------------------------
module quadport_ram_arbiter #(
  parameter int AW    = 9,
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_1,
  input  logic          req_2,
  input  logic          req_3,
  input  logic          req_4,
  input  logic          we_1,
  input  logic          we_2,
  input  logic          we_3,
  input  logic          we_4,
  input  logic [AW-1:0] addr_1,
  input  logic [AW-1:0] addr_2,
  input  logic [AW-1:0] addr_3,
  input  logic [AW-1:0] addr_4,
  input  logic [DW-1:0] wdata_1,
  input  logic [DW-1:0] wdata_2,
  input  logic [DW-1:0] wdata_3,
  input  logic [DW-1:0] wdata_4,
  output logic          gnt_1,
  output logic          gnt_2,
  output logic          gnt_3,
  output logic          gnt_4,
  output logic          rvalid_1,
  output logic          rvalid_2,
  output logic          rvalid_3,
  output logic          rvalid_4,
  output logic [DW-1:0] rdata_1,
  output logic [DW-1:0] rdata_2,
  output logic [DW-1:0] rdata_3,
  output logic [DW-1:0] rdata_4,
  output logic          err_1,
  output logic          err_2,
  output logic          err_3,
  output logic          err_4,
  output logic          ram_we_1,
  output logic          ram_we_2,
  output logic          ram_we_3,
  output logic          ram_we_4,
  output logic          ram_re_1,
  output logic          ram_re_2,
  output logic          ram_re_3,
  output logic          ram_re_4,
  output logic [AW-1:0] ram_addr_1,
  output logic [AW-1:0] ram_addr_2,
  output logic [AW-1:0] ram_addr_3,
  output logic [AW-1:0] ram_addr_4,
  output logic [DW-1:0] ram_din_1,
  output logic [DW-1:0] ram_din_2,
  output logic [DW-1:0] ram_din_3,
  output logic [DW-1:0] ram_din_4,
  input  logic [DW-1:0] ram_dout_1,
  input  logic [DW-1:0] ram_dout_2,
  input  logic [DW-1:0] ram_dout_3,
  input  logic [DW-1:0] ram_dout_4,
  output logic [CW-1:0] conflict_cnt
);

  logic [3:0]    req_s;
  logic [3:0]    we_s;
  logic [3:0]    inr_s;
  logic [AW-1:0] addr_s [4];
  logic [1:0]    ord_s  [4];   // ord_s[k] = port evaluated k-th this cycle
  logic [3:0]    hz_s;         // indexed by order position, not port
  logic [3:0]    gnt_s;
  logic [3:0]    gnt_o_s;
  logic [3:0]    den_ord_s;
  logic [1:0]    first_den_s;
  logic [3:0]    ram_we_s;
  logic [3:0]    ram_re_s;

  logic [1:0]    prio_q, prio_d;
  logic [3:0]    rvalid_q;
  logic [3:0]    err_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign req_s     = {req_4, req_3, req_2, req_1};
  assign we_s      = {we_4, we_3, we_2, we_1};
  assign addr_s[0] = addr_1;
  assign addr_s[1] = addr_2;
  assign addr_s[2] = addr_3;
  assign addr_s[3] = addr_4;

  for (genvar g = 0; g < 4; g++) begin : g_port
    assign inr_s[g] = (32'(addr_s[g]) < 32'(DEPTH));
    assign ord_s[g] = prio_q + 2'(g);
  end

  // Grant in priority order; a port hazards only against earlier granted
  // in-range ports, so out-of-range requests are always granted.
  always_comb begin
    gnt_s = 4'b0000;
    hz_s  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 4; m++) begin
        hz_s[k] = hz_s[k] | ((m < k) && gnt_s[ord_s[m]] && inr_s[ord_s[m]] &&
                             inr_s[ord_s[k]] &&
                             (addr_s[ord_s[k]] == addr_s[ord_s[m]]) &&
                             (we_s[ord_s[k]] || we_s[ord_s[m]]));
      end
      gnt_s[ord_s[k]] = req_s[ord_s[k]] & ~hz_s[k];
    end
  end

  // Denials in order space; the first one (lowest k) becomes next priority.
  always_comb begin
    den_ord_s   = 4'b0000;
    first_den_s = prio_q;
    for (int k = 0; k < 4; k++) begin
      den_ord_s[k] = req_s[ord_s[k]] & hz_s[k];
    end
    for (int k = 3; k >= 0; k--) begin
      if (den_ord_s[k]) begin
        first_den_s = ord_s[k];
      end else begin
        first_den_s = first_den_s;
      end
    end
  end

  assign gnt_o_s  = gnt_s & {4{rst_n}};
  assign ram_we_s = gnt_o_s & we_s & inr_s;
  assign ram_re_s = gnt_o_s & ~we_s & inr_s;

  // Next priority pointer and saturating conflict counter.
  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (|den_ord_s) begin
      prio_d = first_den_s;
      if (cnt_q == {CW{1'b1}}) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else if (|gnt_s) begin
      prio_d = prio_q + 2'd1;
    end else begin
      prio_d = prio_q;
    end
  end

  // State registers; reset drops any in-flight read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= 2'd0;
      rvalid_q <= 4'b0000;
      err_q    <= 4'b0000;
      cnt_q    <= {CW{1'b0}};
    end else begin
      prio_q   <= prio_d;
      rvalid_q <= ram_re_s;
      err_q    <= gnt_o_s & ~inr_s;
      cnt_q    <= cnt_d;
    end
  end

  assign {gnt_4, gnt_3, gnt_2, gnt_1}             = gnt_o_s;
  assign {ram_we_4, ram_we_3, ram_we_2, ram_we_1} = ram_we_s;
  assign {ram_re_4, ram_re_3, ram_re_2, ram_re_1} = ram_re_s;
  assign {rvalid_4, rvalid_3, rvalid_2, rvalid_1} = rvalid_q;
  assign {err_4, err_3, err_2, err_1}             = err_q;
  assign conflict_cnt = cnt_q;

  assign ram_addr_1 = addr_1;
  assign ram_addr_2 = addr_2;
  assign ram_addr_3 = addr_3;
  assign ram_addr_4 = addr_4;
  assign ram_din_1  = wdata_1;
  assign ram_din_2  = wdata_2;
  assign ram_din_3  = wdata_3;
  assign ram_din_4  = wdata_4;
  assign rdata_1    = ram_dout_1;
  assign rdata_2    = ram_dout_2;
  assign rdata_3    = ram_dout_3;
  assign rdata_4    = ram_dout_4;

endmodule

// File: doc/quadport_ram_arbiter.md
Name: quadport_ram_arbiter

Overview:
- Sits between four processor cores and the shared 4-port 16-bit data RAM of the multicore build.
- Each cycle, grants every core whose access does not hazard against a higher-priority granted access.
- Drives the RAM per-port write/read enables, returns read data with a valid strobe, flags out-of-range addresses and counts conflicts.
- Priority rotates so any denied core is served within 3 cycles.

Parameters:
- AW, 9, address width on the core and RAM sides.
- DW, 16, data width.
- DEPTH, 32, number of implemented RAM words; addresses >= DEPTH are out of range.
- CW, 16, conflict counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_n  in  1  core n (n=1..4) access request; held with its fields until gnt_n.
- we_n  in  1  core n: 1=write, 0=read.
- addr_n  in  AW  core n address.
- wdata_n  in  DW  core n write data.
- gnt_n  out  1  combinational grant to core n this cycle.
- rvalid_n  out  1  registered; rdata_n valid (one cycle after a granted in-range read).
- rdata_n  out  DW  read data to core n (passthrough of ram_dout_n).
- err_n  out  1  registered one-cycle pulse: granted access was out of range.
- ram_we_n  out  1  RAM port n write enable.
- ram_re_n  out  1  RAM port n read enable.
- ram_addr_n  out  AW  RAM port n address (= addr_n).
- ram_din_n  out  DW  RAM port n write data (= wdata_n).
- ram_dout_n  in  DW  RAM port n read data.
- conflict_cnt  out  CW  saturating count of cycles with at least one denied request.

Behaviour:
- State: prio[1:0] (index of highest-priority port, 0..3 = core 1..4), rvalid/err registers, conflict_cnt.
- Reset (rst_n low, async): prio=0, all rvalid_n=0, err_n=0, conflict_cnt=0; gnt_n and ram_we_n/ram_re_n forced 0 while rst_n low. In-flight read strobes are dropped; a core must re-request after reset.
- Evaluation order: prio, prio+1, prio+2, prio+3 (mod 4).
- Port i is granted iff req_i=1 and it does not conflict with any already-granted port earlier in the order.
- Conflict between i and j: addr_i==addr_j and (we_i or we_j). Concurrent reads of one address never conflict. Different addresses never conflict.
- Out-of-range requests (addr_i >= DEPTH) do not enter the conflict check. They are always granted, drive no RAM enable, and cause err_i=1 next cycle.
- RAM side: ram_we_i = gnt_i & we_i & in_range; ram_re_i = gnt_i & ~we_i & in_range.
- Latency: writes complete at the grant-cycle edge. Reads: rvalid_i=1 in the cycle after the grant, with rdata_i = ram_dout_i. Same-cycle write and read to one address never co-grant, so no read-during-write ambiguity reaches the RAM.
- Priority update each edge:
  - If any request was denied, prio becomes the first denied port in the current order, and conflict_cnt increments (holds at all-ones).
  - If no request was denied, prio <= prio+1 mod 4 when any grant occurred, else it holds.
- Starvation bound: a denied core becomes top priority next cycle, so its worst-case wait is 3 cycles.
- No req: gnt=0, no RAM enables, no state change except the pointer rule above.
- Dropping req before gnt is legal and leaves no side effect.

Test Plan:
- Reset: rst_n=0 asserted mid-read (rvalid_2 pending) -> all gnt/rvalid/err=0, prio=0, conflict_cnt=0 immediately; after release, idle -> no RAM enables.
- Disjoint access: cores 1..4 write 0x1111..0x4444 to addrs 0..3 in one cycle -> all gnt=1, all ram_we=1. Next cycle, read addrs 3,2,1,0 -> rvalid all 1 one cycle later with rdata 0x4444,0x3333,0x2222,0x1111; conflict_cnt=0.
- Write/write hazard: prio=0, cores 1 and 3 write addr 5 (0xAAAA, 0xBBBB) -> gnt_1=1, gnt_3=0, conflict_cnt=1, prio=2. Next cycle gnt_3=1 and mem[5] ends at 0xBBBB.
- Shared read: all four read addr 7 simultaneously -> all granted, four rvalid next cycle with identical data, no conflict count.
- Starvation: cores 1..4 all write addr 9 continuously -> each core granted exactly once in any 4 consecutive cycles; conflict_cnt +1 per cycle; saturates at 0xFFFF when CW forced to 16 and preloaded near max.
- Out of range: core 4 reads addr 40 -> gnt_4=1, ram_re_4=0, err_4=1 next cycle, rvalid_4=0.
